// File: rtl/seq_divider_if.sv
// Handshake and result bundle for seq_divider: the requester owns start and the
// operands, the divider owns the status and result signals.
`timescale 1ns/1ps
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, WIDTH cycles
// from accept to done, single-cycle divide-by-zero shortcut.
`timescale 1ns/1ps
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CNT_W-1:0] cnt;
    logic             zero_flag;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    // The partial remainder always stays below the divisor, so the trial value is
    // below 2*D: the top bit of (trial - D) is a clean borrow, and a restored
    // remainder always fits WIDTH bits.
    // NOTE: every signal here is assigned on every path, so no latch is inferred.
    always_comb begin
        trial  = {r_reg, q_reg[WIDTH-1]};
        diff   = trial - {1'b0, d_reg};
        fits   = ~diff[WIDTH];
        r_next = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        q_next = {q_reg[WIDTH-2:0], fits};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            d_reg           <= '0;
            q_reg           <= '0;
            r_reg           <= '0;
            cnt             <= '0;
            zero_flag       <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        d_reg     <= bus.divisor;
                        q_reg     <= bus.dividend;
                        r_reg     <= '0;
                        cnt       <= CNT_W'(WIDTH);
                        zero_flag <= (bus.divisor == '0);
                        bus.busy  <= 1'b1;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (zero_flag) begin
                        // q_reg still holds the untouched dividend on this path.
                        bus.quotient    <= '1;
                        bus.remainder   <= q_reg;
                        bus.div_by_zero <= 1'b1;
                        bus.done        <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= DONE;
                    end else begin
                        r_reg <= r_next;
                        q_reg <= q_next;
                        cnt   <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            bus.quotient    <= q_next;
                            bus.remainder   <= r_next;
                            bus.div_by_zero <= 1'b0;
                            bus.done        <= 1'b1;
                            bus.busy        <= 1'b0;
                            state           <= DONE;
                        end
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: a 32-bit and an 8-bit instance, expected
// results queued at stimulus time and compared when done pulses.
`timescale 1ns/1ps
module tb_seq_divider;
    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(32)) bus32 ();
    seq_divider_if #(.WIDTH(8))  bus8 ();

    seq_divider #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    seq_divider #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

    int          total = 0;
    int          bad   = 0;
    exp_t        sb32[$];
    exp_t        sb8[$];
    logic [31:0] held_q;
    logic [31:0] held_r;
    logic        held_z;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] ones);
        exp_t e;
        if (b == 64'd0) begin
            e.q = ones;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic start32(input logic [31:0] a, input logic [31:0] b);
        bus32.dividend = a;
        bus32.divisor  = b;
        bus32.start    = 1'b1;
        sb32.push_back(model(64'(a), 64'(b), 64'hFFFF_FFFF));
        tick();
        bus32.start    = 1'b0;
    endtask

    // Waits for done on the 32-bit unit; optionally pulses a stray start with new
    // operands at RUN cycle inject_at (negative disables).
    task automatic wait32(input int exp_lat, input int inject_at);
        int   cyc      = 0;
        int   busy_cnt = 0;
        exp_t e;
        while (bus32.done !== 1'b1 && cyc < 100) begin
            if (bus32.busy === 1'b1) busy_cnt++;
            check("held_quotient", 64'(bus32.quotient), 64'(held_q));
            check("held_remainder", 64'(bus32.remainder), 64'(held_r));
            if (cyc == inject_at) begin
                bus32.start    = 1'b1;
                bus32.dividend = 32'd9;
                bus32.divisor  = 32'd3;
            end
            tick();
            cyc++;
            if (cyc == inject_at + 1) begin
                bus32.start    = 1'b0;
                bus32.dividend = $urandom;
                bus32.divisor  = $urandom;
            end
        end
        check("latency", 64'(cyc), 64'(exp_lat));
        check("busy_cycles", 64'(busy_cnt), 64'(exp_lat));
        check("busy_in_done", 64'(bus32.busy), 64'd0);
        check("sb32_depth", 64'(sb32.size()), 64'd1);
        if (sb32.size() > 0) begin
            e = sb32.pop_front();
            check("quotient", 64'(bus32.quotient), e.q);
            check("remainder", 64'(bus32.remainder), e.r);
            check("div_by_zero", 64'(bus32.div_by_zero), 64'(e.z));
            held_q = e.q[31:0];
            held_r = e.r[31:0];
            held_z = e.z;
        end
        tick();
        check("done_one_cycle", 64'(bus32.done), 64'd0);
        check("result_hold", 64'(bus32.quotient), 64'(held_q));
    endtask

    initial begin
        exp_t e;
        int   cyc;
        int   pulses;

        rst            = 1'b1;
        bus32.start    = 1'b0;
        bus32.dividend = '0;
        bus32.divisor  = '0;
        bus8.start     = 1'b0;
        bus8.dividend  = '0;
        bus8.divisor   = '0;
        held_q         = '0;
        held_r         = '0;
        held_z         = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_busy", 64'(bus32.busy), 64'd0);
        check("rst_done", 64'(bus32.done), 64'd0);
        check("rst_quotient", 64'(bus32.quotient), 64'd0);
        check("rst_remainder", 64'(bus32.remainder), 64'd0);
        check("rst_dbz", 64'(bus32.div_by_zero), 64'd0);
        check("rst8_quotient", 64'(bus8.quotient), 64'd0);
        check("rst8_busy", 64'(bus8.busy), 64'd0);

        // Normal divisions
        start32(32'd100, 32'd7);
        wait32(32, -1);
        start32(32'hFFFF_FFFF, 32'd1);
        wait32(32, -1);
        start32(32'd5, 32'd9);
        wait32(32, -1);

        // Divide by zero, then a normal division clears the flag
        start32(32'd1234, 32'd0);
        wait32(1, -1);
        start32(32'd10, 32'd3);
        wait32(32, -1);

        // Stray start and operand changes during RUN are ignored
        start32(32'd100, 32'd7);
        wait32(32, 10);

        // Reset in the middle of RUN aborts without a done pulse
        start32(32'd100, 32'd7);
        repeat (15) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if (sb32.size() > 0) e = sb32.pop_front();
        held_q = '0;
        held_r = '0;
        held_z = 1'b0;
        check("abort_busy", 64'(bus32.busy), 64'd0);
        check("abort_done", 64'(bus32.done), 64'd0);
        check("abort_quotient", 64'(bus32.quotient), 64'd0);
        check("abort_remainder", 64'(bus32.remainder), 64'd0);
        check("abort_dbz", 64'(bus32.div_by_zero), 64'd0);
        pulses = 0;
        repeat (40) begin
            tick();
            if (bus32.done === 1'b1) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);
        start32(32'd50, 32'd5);
        wait32(32, -1);

        // rst and start on the same edge: reset wins
        rst            = 1'b1;
        bus32.start    = 1'b1;
        bus32.dividend = 32'd77;
        bus32.divisor  = 32'd1;
        tick();
        rst         = 1'b0;
        bus32.start = 1'b0;
        check("rst_start_busy", 64'(bus32.busy), 64'd0);
        tick();
        check("rst_start_done", 64'(bus32.done), 64'd0);
        check("rst_start_quotient", 64'(bus32.quotient), 64'd0);

        // 8-bit back-to-back with start held high through the done cycle
        bus8.dividend = 8'd200;
        bus8.divisor  = 8'd13;
        bus8.start    = 1'b1;
        sb8.push_back(model(64'd200, 64'd13, 64'hFF));
        tick();
        bus8.dividend = 8'd255;
        bus8.divisor  = 8'd16;
        sb8.push_back(model(64'd255, 64'd16, 64'hFF));
        cyc = 0;
        while (bus8.done !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("w8_first_latency", 64'(cyc), 64'd8);
        if (sb8.size() > 0) begin
            e = sb8.pop_front();
            check("w8_first_quotient", 64'(bus8.quotient), e.q);
            check("w8_first_remainder", 64'(bus8.remainder), e.r);
            check("w8_first_dbz", 64'(bus8.div_by_zero), 64'(e.z));
        end
        tick();
        cyc        = 1;
        bus8.start = 1'b0;
        check("w8_b2b_done_low", 64'(bus8.done), 64'd0);
        check("w8_b2b_busy", 64'(bus8.busy), 64'd1);
        while (bus8.done !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("w8_second_latency", 64'(cyc), 64'd9);
        check("sb8_depth", 64'(sb8.size()), 64'd1);
        if (sb8.size() > 0) begin
            e = sb8.pop_front();
            check("w8_second_quotient", 64'(bus8.quotient), e.q);
            check("w8_second_remainder", 64'(bus8.remainder), e.r);
            check("w8_second_dbz", 64'(bus8.div_by_zero), 64'(e.z));
        end
        tick();
        check("w8_final_done_low", 64'(bus8.done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
